// File: rtl/cpu_run_ctrl.sv
// Host-side run controller: pulses the CPU reset on a start request, runs the CPU with a
// cycle counter and watchdog, then reports completion through a four-phase ack.
module cpu_run_ctrl #(
  parameter int unsigned RST_CYC = 2,
  parameter int unsigned CW      = 16,
  parameter int unsigned MAX_CYC = 65535
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          cpu_done,
  output logic          cpu_reset,
  output logic          busy,
  output logic          ack,
  output logic          timeout,
  output logic [CW-1:0] cycles
);

  localparam int unsigned RcW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RcW-1:0] RstLast = RcW'(RST_CYC - 1);
  localparam logic [CW-1:0]  CycLast = CW'(MAX_CYC - 1);
  localparam logic [CW-1:0]  CycMax  = CW'(MAX_CYC);

  typedef enum logic [1:0] {StIdle, StReset, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [RcW-1:0] rst_cnt_q, rst_cnt_d;
  logic [CW-1:0]  cycles_q, cycles_d;
  logic           cpu_reset_q, cpu_reset_d;
  logic           busy_q, busy_d;
  logic           ack_q, ack_d;
  logic           timeout_q, timeout_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rst_cnt_q   <= '0;
      cycles_q    <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cycles_q    <= cycles_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req) state_d = StReset;
      StReset: if (rst_cnt_q == RstLast) state_d = StRun;
      StRun:   if (cpu_done || (cycles_q == CycLast)) state_d = StDone;
      StDone:  if (!req) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs; every output is a flop, never a decode of state.
  always_comb begin
    rst_cnt_d   = rst_cnt_q;
    cycles_d    = cycles_q;
    cpu_reset_d = cpu_reset_q;
    busy_d      = busy_q;
    ack_d       = ack_q;
    timeout_d   = timeout_q;
    unique case (state_q)
      StIdle: begin
        cpu_reset_d = 1'b1;
        ack_d       = 1'b0;
        if (req) begin
          cycles_d  = '0;
          timeout_d = 1'b0;
          busy_d    = 1'b1;
          rst_cnt_d = '0;
        end
      end
      StReset: begin
        rst_cnt_d = rst_cnt_q + RcW'(1);
        if (rst_cnt_q == RstLast) cpu_reset_d = 1'b0;
      end
      StRun: begin
        // Done has priority over the watchdog and freezes the count at its pre-edge value.
        if (cpu_done) begin
          ack_d       = 1'b1;
          busy_d      = 1'b0;
          cpu_reset_d = 1'b1;
          timeout_d   = 1'b0;
        end else if (cycles_q == CycLast) begin
          cycles_d    = CycMax;
          timeout_d   = 1'b1;
          ack_d       = 1'b1;
          busy_d      = 1'b0;
          cpu_reset_d = 1'b1;
        end else begin
          cycles_d = cycles_q + CW'(1);
        end
      end
      StDone: begin
        if (!req) ack_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign ack       = ack_q;
  assign timeout   = timeout_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with RST_CYC=2, MAX_CYC=20.
module tb_cpu_run_ctrl;

  localparam int unsigned CW = 16;

  logic          clk;
  logic          reset;
  logic          req;
  logic          cpu_done;
  logic          cpu_reset;
  logic          busy;
  logic          ack;
  logic          timeout;
  logic [CW-1:0] cycles;

  int n_chk  = 0;
  int n_pass = 0;

  cpu_run_ctrl #(
    .RST_CYC(2),
    .CW     (CW),
    .MAX_CYC(20)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .cpu_done (cpu_done),
    .cpu_reset(cpu_reset),
    .busy     (busy),
    .ack      (ack),
    .timeout  (timeout),
    .cycles   (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    reset    = 1'b0;
    req      = 1'b1;
    cpu_done = 1'b0;

    // 1: reset held with req high
    repeat (3) step();
    chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_cycles", 32'(cycles), 0);
    reset = 1'b1;

    // 2: normal finish after 5 RUN edges
    step();
    chk("t2_busy_reset", 32'(busy), 1);
    chk("t2_cpurst_e0", 32'(cpu_reset), 1);
    step();
    chk("t2_cpurst_e1", 32'(cpu_reset), 1);
    step();
    chk("t2_cpurst_run", 32'(cpu_reset), 0);
    chk("t2_cycles_run0", 32'(cycles), 0);
    repeat (5) step();
    chk("t2_cycles5", 32'(cycles), 5);
    chk("t2_busy_run", 32'(busy), 1);
    cpu_done = 1'b1;
    step();
    cpu_done = 1'b0;
    chk("t2_ack", 32'(ack), 1);
    chk("t2_timeout", 32'(timeout), 0);
    chk("t2_cycles", 32'(cycles), 5);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_cpurst", 32'(cpu_reset), 1);
    req = 1'b0;
    step();
    chk("t2_ack_drop", 32'(ack), 0);

    // 3: watchdog timeout
    req = 1'b1;
    repeat (3) step();
    chk("t3_cycles_clr", 32'(cycles), 0);
    repeat (19) step();
    chk("t3_cycles19", 32'(cycles), 19);
    chk("t3_ack_pre", 32'(ack), 0);
    step();
    chk("t3_ack", 32'(ack), 1);
    chk("t3_timeout", 32'(timeout), 1);
    chk("t3_cycles", 32'(cycles), 20);
    chk("t3_busy", 32'(busy), 0);
    repeat (2) step();
    chk("t3_cycles_hold", 32'(cycles), 20);
    req = 1'b0;
    step();
    chk("t3_ack_drop", 32'(ack), 0);
    chk("t3_cycles_kept", 32'(cycles), 20);
    chk("t3_timeout_kept", 32'(timeout), 1);

    // 4: done and watchdog limit on the same edge
    req = 1'b1;
    step();
    chk("t4_timeout_clr", 32'(timeout), 0);
    repeat (2) step();
    repeat (19) step();
    chk("t4_cycles19", 32'(cycles), 19);
    cpu_done = 1'b1;
    step();
    cpu_done = 1'b0;
    chk("t4_ack", 32'(ack), 1);
    chk("t4_timeout", 32'(timeout), 0);
    chk("t4_cycles", 32'(cycles), 19);
    req = 1'b0;
    step();

    // 5: cpu_done ignored during RESET, no restart while req stays high
    cpu_done = 1'b1;
    req      = 1'b1;
    repeat (3) step();
    chk("t5_ack_reset", 32'(ack), 0);
    chk("t5_cpurst_run", 32'(cpu_reset), 0);
    step();
    chk("t5_ack", 32'(ack), 1);
    chk("t5_cycles", 32'(cycles), 0);
    cpu_done = 1'b0;
    repeat (10) step();
    chk("t5_ack_hold", 32'(ack), 1);
    chk("t5_busy_hold", 32'(busy), 0);
    chk("t5_cpurst_hold", 32'(cpu_reset), 1);
    req = 1'b0;
    step();

    // 6: asynchronous reset mid-RUN, then a fresh run
    req = 1'b1;
    repeat (3) step();
    repeat (7) step();
    chk("t6_cycles7", 32'(cycles), 7);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_async_cpurst", 32'(cpu_reset), 1);
    chk("t6_async_busy", 32'(busy), 0);
    chk("t6_async_cycles", 32'(cycles), 0);
    step();
    reset = 1'b1;
    step();
    chk("t6_restart_busy", 32'(busy), 1);
    repeat (2) step();
    chk("t6_restart_run", 32'(cpu_reset), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
